mem_tid_arbiter: RTL and testbench
==================================

MEM_TID_ARBITER -- requirements
Module: mem_tid_arbiter

Interface
REQ-001 SHALL have parameter: FIXED_PRIO, 0, 0 = round-robin between masters, 1 = master 0 always wins.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state rising-edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports, per master mN (N=0,1): mN_req in 1 request; mN_addr in 32 address; mN_cmd in 1 (1=write, 0=read); mN_wdata in 32 write data.
REQ-005 SHALL have ports, per master: mN_ack out 1 request accepted; mN_resp out 1 read data valid; mN_rdata out 32 read data.
REQ-006 SHALL have slave ports: slave_req out 1; slave_addr out 32; slave_cmd out 1; slave_wdata out 32; slave_ack in 1; slave_reqtid in 2 (tid assigned to an accepted read, same cycle).
REQ-007 SHALL have slave response ports: slave_resp in 1; slave_resptid in 2; slave_rdata in 32.
REQ-008 SHALL have status ports: outst0 out 3, outst1 out 3 (outstanding reads per master, 0..4); err_o out 1 (sticky protocol error).

Function
REQ-009 SHALL select grant combinationally among asserted mN_req; the selected master's addr/cmd/wdata drive the slave ports; slave_req = OR of mN_req.
REQ-010 SHALL, with FIXED_PRIO=0, grant master rr_ptr when both request; rr_ptr resets to 0 and toggles to the non-winner only on an accepted transfer (slave_req & slave_ack).
REQ-011 SHALL keep the grant unchanged while slave_req is high and slave_ack is low (no re-arbitration without acceptance, given held requests).
REQ-012 SHALL drive mN_ack = slave_ack & granted(N); the non-granted master's ack SHALL be 0.
REQ-013 SHALL, on an accepted read, write owner[slave_reqtid] = granted master and set valid[slave_reqtid] at the next edge.
REQ-014 SHALL, on slave_resp, route combinationally: m{owner[slave_resptid]}_resp = 1 and its rdata = slave_rdata; the other master's resp = 0, rdata = 0; valid[slave_resptid] clears at the next edge.
REQ-015 SHALL, when a response frees tid T and an accepted read is assigned tid T in the same cycle, leave valid[T]=1 with the new owner (allocation wins).
REQ-016 SHALL produce no response or table entry for writes; a write is complete on ack.
REQ-017 SHALL increment outstN on an accepted read by N, decrement on a response routed to N; simultaneous increment and decrement leave outstN unchanged.
REQ-018 SHALL set err_o (sticky until reset) on slave_resp with valid[slave_resptid]=0, or on an accepted read whose slave_reqtid is already valid and not freed that cycle; no response SHALL be forwarded for an unowned tid.
REQ-019 SHALL impose zero added latency: request and response paths are combinational; only the owner/valid table, counters, rr_ptr and err_o are registered.
REQ-020 SHALL drive all mN_* and slave_* outputs to 0 when no request and no response is present.

Reset
REQ-021 SHALL, while rst_i is high, asynchronously clear valid[3:0], owner[3:0], rr_ptr, outst0, outst1 and err_o to 0.
REQ-022 SHALL discard all in-flight tid ownership on reset mid-operation; responses arriving after reset for pre-reset tids SHALL set err_o.
REQ-023 SHALL resume arbitration on the first clock edge after rst_i deasserts.

Verification
REQ-024 Bench SHALL cover: both masters request reads continuously, slave always acks -> grants alternate m0,m1,m0,...; outst0 = outst1 = 2 after 4 accepts with no responses.
REQ-025 Bench SHALL cover: m0 reads tid 0, m1 reads tid 1, slave answers tid 1 (rdata 0x11111111) then tid 0 (0x00000000) -> m1_resp first with 0x11111111, then m0_resp; no cross-routing.
REQ-026 Bench SHALL cover: slave_ack held 0 for 3 cycles with both requesting -> grant and slave_addr constant, rr_ptr unchanged until the ack cycle.
REQ-027 Bench SHALL cover: response on tid 2 and new m1 read assigned tid 2 in the same cycle -> response goes to the previous owner, owner[2]=1 and valid[2]=1 afterward, err_o stays 0.
REQ-028 Bench SHALL cover: slave_resp on tid 3 with valid[3]=0 -> m0_resp = m1_resp = 0, err_o = 1 persisting until rst_i.
REQ-029 Bench SHALL cover: FIXED_PRIO=1 with both requesting -> m0 granted every cycle and m1_ack = 0 until m0_req drops.

Source files
------------

// File: rtl/mem_tid_arbiter.sv
// mem_tid_arbiter: two-master arbiter onto a tagged slave, routing read responses back by tid owner
module mem_tid_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_cmd,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_resp,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_cmd,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_resp,
  output logic [31:0] m1_rdata,
  output logic        slave_req,
  output logic [31:0] slave_addr,
  output logic        slave_cmd,
  output logic [31:0] slave_wdata,
  input  logic        slave_ack,
  input  logic [1:0]  slave_reqtid,
  input  logic        slave_resp,
  input  logic [1:0]  slave_resptid,
  input  logic [31:0] slave_rdata,
  output logic [2:0]  outst0,
  output logic [2:0]  outst1,
  output logic        err_o
);
  logic       rr_ptr, sel0, sel1, acc, rd_acc, rsp_ok, conflict;
  logic [3:0] valid, owner;
  // rr_ptr only moves on acceptance, so a stalled grant stays put while requests are held
  assign sel1 = FIXED_PRIO ? (m1_req & ~m0_req) : (m1_req & (~m0_req | rr_ptr));
  assign sel0 = m0_req & ~sel1;
  assign slave_req   = m0_req | m1_req;
  assign slave_addr  = sel1 ? m1_addr : sel0 ? m0_addr : '0;
  assign slave_cmd   = sel1 ? m1_cmd : sel0 & m0_cmd;
  assign slave_wdata = sel1 ? m1_wdata : sel0 ? m0_wdata : '0;
  assign m0_ack = slave_ack & sel0;
  assign m1_ack = slave_ack & sel1;
  assign acc    = slave_req & slave_ack;
  assign rd_acc = acc & ~slave_cmd;
  assign rsp_ok  = slave_resp & valid[slave_resptid];
  assign m0_resp = rsp_ok & ~owner[slave_resptid];
  assign m1_resp = rsp_ok & owner[slave_resptid];
  assign m0_rdata = m0_resp ? slave_rdata : '0;
  assign m1_rdata = m1_resp ? slave_rdata : '0;
  assign conflict = rd_acc & valid[slave_reqtid] & ~(rsp_ok & (slave_resptid == slave_reqtid));
  // allocation is written after the free so a same-cycle reuse of a tid keeps it valid
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid  <= '0;
      owner  <= '0;
      rr_ptr <= 1'b0;
      outst0 <= '0;
      outst1 <= '0;
      err_o  <= 1'b0;
    end else begin
      if (rsp_ok) valid[slave_resptid] <= 1'b0;
      if (rd_acc) begin
        valid[slave_reqtid] <= 1'b1;
        owner[slave_reqtid] <= sel1;
      end
      if (acc) rr_ptr <= sel0;
      outst0 <= outst0 + 3'(rd_acc & sel0) - 3'(m0_resp);
      outst1 <= outst1 + 3'(rd_acc & sel1) - 3'(m1_resp);
      err_o  <= err_o | (slave_resp & ~valid[slave_resptid]) | conflict;
    end
  end
endmodule

// File: tb/tb_mem_tid_arbiter.sv
// tb_mem_tid_arbiter: vector table, directed corner sequences and a random run against a tid-ownership model
module tb_mem_tid_arbiter;
  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        m0_req, m0_cmd, m1_req, m1_cmd, slave_ack, slave_resp;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, slave_rdata;
  logic [1:0]  slave_reqtid, slave_resptid;
  logic        m0_ack, m0_resp, m1_ack, m1_resp, slave_req, slave_cmd, err_o;
  logic [31:0] m0_rdata, m1_rdata, slave_addr, slave_wdata;
  logic [2:0]  outst0, outst1;
  logic        f_m0_ack, f_m0_resp, f_m1_ack, f_m1_resp, f_slave_req, f_slave_cmd, f_err;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_slave_addr, f_slave_wdata;
  logic [2:0]  f_outst0, f_outst1;
  int checks = 0, errors = 0;
  int own[4];
  int rr, cnt[2];
  bit merr;

  localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hB000_0000;

  always #5 clk_i = ~clk_i;

  mem_tid_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_cmd(m0_cmd), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_resp(m0_resp), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_cmd(m1_cmd), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_resp(m1_resp), .m1_rdata(m1_rdata),
    .slave_req(slave_req), .slave_addr(slave_addr), .slave_cmd(slave_cmd), .slave_wdata(slave_wdata),
    .slave_ack(slave_ack), .slave_reqtid(slave_reqtid),
    .slave_resp(slave_resp), .slave_resptid(slave_resptid), .slave_rdata(slave_rdata),
    .outst0(outst0), .outst1(outst1), .err_o(err_o)
  );

  mem_tid_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_cmd(m0_cmd), .m0_wdata(m0_wdata),
    .m0_ack(f_m0_ack), .m0_resp(f_m0_resp), .m0_rdata(f_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_cmd(m1_cmd), .m1_wdata(m1_wdata),
    .m1_ack(f_m1_ack), .m1_resp(f_m1_resp), .m1_rdata(f_m1_rdata),
    .slave_req(f_slave_req), .slave_addr(f_slave_addr), .slave_cmd(f_slave_cmd), .slave_wdata(f_slave_wdata),
    .slave_ack(slave_ack), .slave_reqtid(slave_reqtid),
    .slave_resp(slave_resp), .slave_resptid(slave_resptid), .slave_rdata(slave_rdata),
    .outst0(f_outst0), .outst1(f_outst1), .err_o(f_err)
  );

  typedef struct {
    logic r0, r1, ack;
    logic [1:0] tid;
    logic a0, a1;
    logic [31:0] addr;
    logic [2:0] o0, o1;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    m0_req = 0; m1_req = 0; m0_cmd = 0; m1_cmd = 0; slave_ack = 0; slave_resp = 0;
    m0_addr = A0; m1_addr = A1; m0_wdata = 32'h0; m1_wdata = 32'h0;
    slave_rdata = 32'h0; slave_reqtid = 0; slave_resptid = 0;
  endtask

  task automatic do_reset();
    clr();
    rst_i = 1;
    tick();
    tick();
    rst_i = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) own[i] = -1;
    rr = 0; cnt[0] = 0; cnt[1] = 0; merr = 0;
  endtask

  function automatic int winner();
    if (m0_req && m1_req) return rr;
    return m1_req ? 1 : 0;
  endfunction

  task automatic check_comb();
    int any, w, ro;
    any = m0_req | m1_req;
    w = winner();
    ro = slave_resp ? own[slave_resptid] : -1;
    chk("slave_req", slave_req, any);
    chk("slave_addr", slave_addr, !any ? 0 : (w == 1 ? m1_addr : m0_addr));
    chk("slave_cmd", slave_cmd, !any ? 0 : (w == 1 ? m1_cmd : m0_cmd));
    chk("slave_wdata", slave_wdata, !any ? 0 : (w == 1 ? m1_wdata : m0_wdata));
    chk("m0_ack", m0_ack, slave_ack && any && w == 0);
    chk("m1_ack", m1_ack, slave_ack && any && w == 1);
    chk("m0_resp", m0_resp, ro == 0);
    chk("m1_resp", m1_resp, ro == 1);
    chk("m0_rdata", m0_rdata, ro == 0 ? slave_rdata : 0);
    chk("m1_rdata", m1_rdata, ro == 1 ? slave_rdata : 0);
    chk("fp_m0_ack", f_m0_ack, slave_ack && m0_req);
    chk("fp_m1_ack", f_m1_ack, slave_ack && m1_req && !m0_req);
    chk("fp_slave_addr", f_slave_addr, m0_req ? m0_addr : (m1_req ? m1_addr : 0));
  endtask

  task automatic model_update();
    int any, w, ro;
    logic wcmd;
    any = m0_req | m1_req;
    w = winner();
    wcmd = w == 1 ? m1_cmd : m0_cmd;
    ro = slave_resp ? own[slave_resptid] : -1;
    if (slave_resp && ro < 0) merr = 1;
    if (ro >= 0) begin
      own[slave_resptid] = -1;
      cnt[ro]--;
    end
    if (any && slave_ack && !wcmd) begin
      if (own[slave_reqtid] >= 0) merr = 1;
      own[slave_reqtid] = w;
      cnt[w]++;
    end
    if (any && slave_ack) rr = 1 - w;
  endtask

  task automatic check_regs();
    chk("outst0", outst0, cnt[0]);
    chk("outst1", outst1, cnt[1]);
    chk("err_o", err_o, merr);
  endtask

  initial begin
    int owned[$], fr[$];
    tbl[0] = '{1, 1, 0, 0, 0, 0, A0, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 0, 0, A0, 0, 0};
    tbl[2] = '{1, 1, 0, 0, 0, 0, A0, 0, 0};
    tbl[3] = '{1, 1, 1, 0, 1, 0, A0, 1, 0};
    tbl[4] = '{1, 1, 1, 1, 0, 1, A1, 1, 1};
    tbl[5] = '{1, 1, 1, 2, 1, 0, A0, 2, 1};
    tbl[6] = '{1, 1, 1, 3, 0, 1, A1, 2, 2};
    do_reset();
    #1;
    chk("reset_outst0", outst0, 0);
    chk("reset_outst1", outst1, 0);
    chk("reset_err", err_o, 0);
    chk("idle_slave_req", slave_req, 0);
    chk("idle_slave_addr", slave_addr, 0);
    chk("idle_resp", {m0_resp, m1_resp, m0_ack, m1_ack}, 0);
    // stalled grant, then alternating accepted reads
    foreach (tbl[i]) begin
      m0_req = tbl[i].r0; m1_req = tbl[i].r1; slave_ack = tbl[i].ack; slave_reqtid = tbl[i].tid;
      #1;
      chk($sformatf("tbl%0d_m0_ack", i), m0_ack, tbl[i].a0);
      chk($sformatf("tbl%0d_m1_ack", i), m1_ack, tbl[i].a1);
      chk($sformatf("tbl%0d_addr", i), slave_addr, tbl[i].addr);
      tick();
      chk($sformatf("tbl%0d_outst0", i), outst0, tbl[i].o0);
      chk($sformatf("tbl%0d_outst1", i), outst1, tbl[i].o1);
      chk($sformatf("tbl%0d_err", i), err_o, 0);
    end
    // out-of-order responses
    do_reset();
    m0_req = 1; slave_ack = 1; slave_reqtid = 0;
    #1 chk("ooo_m0_ack", m0_ack, 1);
    tick();
    m0_req = 0; m1_req = 1; slave_reqtid = 1;
    #1 chk("ooo_m1_ack", m1_ack, 1);
    tick();
    chk("ooo_outst0", outst0, 1);
    chk("ooo_outst1", outst1, 1);
    clr();
    slave_resp = 1; slave_resptid = 1; slave_rdata = 32'h1111_1111;
    #1;
    chk("ooo_r1_m1_resp", m1_resp, 1);
    chk("ooo_r1_m1_rdata", m1_rdata, 32'h1111_1111);
    chk("ooo_r1_m0_resp", m0_resp, 0);
    chk("ooo_r1_m0_rdata", m0_rdata, 0);
    tick();
    chk("ooo_outst1_after", outst1, 0);
    slave_resptid = 0; slave_rdata = 32'h0;
    #1;
    chk("ooo_r0_m0_resp", m0_resp, 1);
    chk("ooo_r0_m1_resp", m1_resp, 0);
    tick();
    chk("ooo_outst0_after", outst0, 0);
    chk("ooo_err", err_o, 0);
    // free and reallocate tid 2 in one cycle
    clr();
    m0_req = 1; slave_ack = 1; slave_reqtid = 2;
    tick();
    clr();
    m1_req = 1; slave_ack = 1; slave_reqtid = 2;
    slave_resp = 1; slave_resptid = 2; slave_rdata = 32'hCAFE_F00D;
    #1;
    chk("reuse_m0_resp", m0_resp, 1);
    chk("reuse_m0_rdata", m0_rdata, 32'hCAFE_F00D);
    chk("reuse_m1_resp", m1_resp, 0);
    chk("reuse_m1_ack", m1_ack, 1);
    tick();
    chk("reuse_err", err_o, 0);
    chk("reuse_outst0", outst0, 0);
    chk("reuse_outst1", outst1, 1);
    clr();
    slave_resp = 1; slave_resptid = 2; slave_rdata = 32'h2222_2222;
    #1 chk("reuse_new_owner", {m0_resp, m1_resp}, 2'b01);
    tick();
    chk("reuse_outst1_after", outst1, 0);
    chk("reuse_err_after", err_o, 0);
    // response on an unowned tid
    clr();
    slave_resp = 1; slave_resptid = 3; slave_rdata = 32'h3333_3333;
    #1;
    chk("unowned_resp", {m0_resp, m1_resp}, 0);
    chk("unowned_rdata", m0_rdata | m1_rdata, 0);
    tick();
    clr();
    chk("unowned_err", err_o, 1);
    repeat (3) tick();
    chk("unowned_err_sticky", err_o, 1);
    do_reset();
    chk("err_cleared", err_o, 0);
    // reset in flight drops ownership, asynchronously
    m0_req = 1; slave_ack = 1; slave_reqtid = 1;
    tick();
    clr();
    chk("inflight_outst0", outst0, 1);
    #2 rst_i = 1;
    #1 chk("async_outst0", outst0, 0);
    tick();
    rst_i = 0;
    slave_resp = 1; slave_resptid = 1;
    #1 chk("stale_resp", m0_resp, 0);
    tick();
    chk("stale_err", err_o, 1);
    // fixed priority instance
    do_reset();
    m0_req = 1; m1_req = 1; m0_cmd = 1; m1_cmd = 1; slave_ack = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_m0_ack_hold", f_m0_ack, 1);
      chk("fp_m1_ack_hold", f_m1_ack, 0);
      chk("fp_addr_hold", f_slave_addr, A0);
      tick();
    end
    m0_req = 0;
    #1 chk("fp_m1_after_drop", f_m1_ack, 1);
    tick();
    // randomized run against the ownership model
    for (int c = 0; c < 2000; c++) begin
      if (c % 250 == 0) begin
        do_reset();
        model_reset();
        check_regs();
      end
      m0_req = $urandom_range(0, 3) != 0; m1_req = $urandom_range(0, 3) != 0;
      m0_cmd = $urandom_range(0, 1); m1_cmd = $urandom_range(0, 1);
      m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
      slave_ack = $urandom_range(0, 3) != 0;
      slave_resp = $urandom_range(0, 1); slave_rdata = $urandom;
      owned.delete(); fr.delete();
      for (int t = 0; t < 4; t++) if (own[t] >= 0) owned.push_back(t); else fr.push_back(t);
      if (owned.size() > 0 && $urandom_range(0, 9) != 0)
        slave_resptid = 2'(owned[$urandom_range(0, owned.size() - 1)]);
      else
        slave_resptid = 2'($urandom_range(0, 3));
      if (slave_resp && own[slave_resptid] >= 0 && $urandom_range(0, 3) == 0)
        slave_reqtid = slave_resptid;
      else if (fr.size() > 0)
        slave_reqtid = 2'(fr[$urandom_range(0, fr.size() - 1)]);
      else begin
        slave_reqtid = 2'($urandom_range(0, 3));
        m0_cmd = 1; m1_cmd = 1;
      end
      #1;
      check_comb();
      model_update();
      tick();
      check_regs();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
